// File: rtl/sort_32_u8_stream_ctrl_pkg.sv
// Shared sizes, FSM state type and frame-buffer type for the byte-sorter
// stream controller.
package sort_pkg;

   localparam int unsigned SORT_N = 32;
   localparam int unsigned SORT_W = 8;
   localparam int unsigned IDX_W  = $clog2(SORT_N);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SORT_N - 1);

   typedef enum logic [2:0] {
      StLoad,
      StPad,
      StFire,
      StWait,
      StDrain
   } state_e;

   // Slot k occupies bits [8k+7:8k] when flattened.
   typedef logic [SORT_N-1:0][SORT_W-1:0] frame_t;

endpackage

// File: rtl/sort_32_u8_stream_ctrl_frame_buf.sv
// 32x8 register file: indexed byte write, pad-fill from an index to the top,
// whole-frame parallel load and a flat read port.
module sort_frame_buf
   import sort_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [SORT_W-1:0] wdata,
   input  logic              fill_en,
   input  logic [IDX_W-1:0]  fill_from,
   input  logic [SORT_W-1:0] fill_val,
   input  logic              load_en,
   input  frame_t            load_data,
   output frame_t            rdata
);

   frame_t mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else if (load_en) begin
         mem_q <= load_data;
      end else begin
         for (int k = 0; k < SORT_N; k++) begin
            if (fill_en && (k >= int'(fill_from))) begin
               mem_q[k] <= fill_val;
            end else if (we && (k == int'(waddr))) begin
               mem_q[k] <= wdata;
            end
         end
      end
   end

   assign rdata = mem_q;

endmodule

// File: rtl/sort_32_u8_stream_ctrl.sv
// Byte-stream front end and sequencer for the 32-entry byte sorter: collect,
// pad, fire, wait under a timeout, then drain the sorted frame with backpressure.
module sort_32_u8_stream_ctrl
   import sort_pkg::*;
#(
   parameter logic [SORT_W-1:0] PAD_VAL = 8'hFF,
   parameter int unsigned       TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   input  logic [SORT_W-1:0]        s_data,
   input  logic                     s_last,
   output logic                     s_ready,
   output logic                     m_valid,
   output logic [SORT_W-1:0]        m_data,
   output logic                     m_last,
   input  logic                     m_ready,
   output logic                     sort_vld_in,
   output logic [SORT_N*SORT_W-1:0] sort_din,
   input  logic                     sort_vld_out,
   input  logic [SORT_N*SORT_W-1:0] sort_dout,
   output logic                     err_timeout,
   output logic                     busy
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic [7:0]        tmo_q, tmo_d;
   logic              err_q, err_d;
   logic [SORT_W-1:0] m_data_q, m_data_d;
   logic              s_ready_q, m_valid_q, m_last_q, vld_in_q, busy_q;
   logic              ld_we, ld_fill, dr_load;
   logic              s_hs, m_hs;
   frame_t            ld_frame, dr_frame;

   sort_frame_buf u_load_buf (
      .clk       (clk),
      .rst       (rst),
      .we        (ld_we),
      .waddr     (wr_idx_q),
      .wdata     (s_data),
      .fill_en   (ld_fill),
      .fill_from (wr_idx_q),
      .fill_val  (PAD_VAL),
      .load_en   (1'b0),
      .load_data ('0),
      .rdata     (ld_frame)
   );

   sort_frame_buf u_drain_buf (
      .clk       (clk),
      .rst       (rst),
      .we        (1'b0),
      .waddr     ('0),
      .wdata     ('0),
      .fill_en   (1'b0),
      .fill_from ('0),
      .fill_val  ('0),
      .load_en   (dr_load),
      .load_data (frame_t'(sort_dout)),
      .rdata     (dr_frame)
   );

   // Handshakes use the registered ready/valid so they match what the ports show.
   assign s_hs = s_valid & s_ready_q;
   assign m_hs = m_valid_q & m_ready;

   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      m_data_d = m_data_q;
      ld_we    = 1'b0;
      ld_fill  = 1'b0;
      dr_load  = 1'b0;
      unique case (state_q)
         StLoad: begin
            if (s_hs) begin
               ld_we = 1'b1;
               if (wr_idx_q == IDX_LAST) begin
                  state_d  = StFire;
                  wr_idx_d = '0;
               end else begin
                  wr_idx_d = wr_idx_q + 5'd1;
                  if (s_last) begin
                     state_d = StPad;
                  end
               end
            end
         end
         StPad: begin
            ld_fill  = 1'b1;
            wr_idx_d = '0;
            state_d  = StFire;
         end
         StFire: begin
            tmo_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (sort_vld_out) begin
               dr_load  = 1'b1;
               rd_idx_d = '0;
               m_data_d = sort_dout[SORT_W-1:0];
               state_d  = StDrain;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = StLoad;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         StDrain: begin
            if (m_hs) begin
               if (rd_idx_q == IDX_LAST) begin
                  rd_idx_d = '0;
                  m_data_d = '0;
                  state_d  = StLoad;
               end else begin
                  rd_idx_d = rd_idx_q + 5'd1;
                  m_data_d = dr_frame[rd_idx_d];
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StLoad;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         m_data_q  <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         vld_in_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         m_data_q  <= m_data_d;
         // Outputs are registered from next state so they line up with state_q.
         s_ready_q <= (state_d == StLoad);
         m_valid_q <= (state_d == StDrain);
         m_last_q  <= (state_d == StDrain) && (rd_idx_d == IDX_LAST);
         vld_in_q  <= (state_d == StFire);
         busy_q    <= !((state_d == StLoad) && (wr_idx_d == '0));
      end
   end

   assign s_ready     = s_ready_q;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_last      = m_last_q;
   assign sort_vld_in = vld_in_q;
   assign sort_din    = ld_frame;
   assign err_timeout = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_sort_32_u8_stream_ctrl.sv
// Directed bench for the sorter stream controller with a behavioural sorter
// (latency 1) that can be switched off to provoke the timeout.
module tb_sort_32_u8_stream_ctrl;

   localparam int TMO = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_valid, s_last, s_ready;
   logic [7:0]   s_data;
   logic         m_valid, m_last, m_ready;
   logic [7:0]   m_data;
   logic         sort_vld_in, sort_vld_out;
   logic [255:0] sort_din, sort_dout;
   logic         err_timeout, busy;

   logic         sorter_on;
   logic         mdl_vld = 1'b0;
   logic [255:0] mdl_dout = '0;
   logic         stray_vld;
   logic [255:0] stray_dout = {32{8'hA5}};

   int total = 0;
   int bad = 0;
   int fire_cnt = 0;
   int exp_fires = 0;
   int cyc;

   logic [7:0] frm [32];
   logic [7:0] exp_q [32];
   logic [7:0] full_in [32] = '{31, 29, 27, 25, 23, 21, 19, 17, 15, 13, 11, 9, 7, 5, 3, 1,
                                2, 2, 4, 4, 4, 4, 8, 16, 8, 16, 32, 32, 0, 10, 20, 30};
   logic [7:0] full_sorted [32] = '{0, 1, 2, 2, 3, 4, 4, 4, 4, 5, 7, 8, 8, 9, 10, 11,
                                    13, 15, 16, 16, 17, 19, 20, 21, 23, 25, 27, 29, 30, 31,
                                    32, 32};

   assign sort_vld_out = mdl_vld | stray_vld;
   assign sort_dout    = mdl_vld ? mdl_dout : stray_dout;

   sort_32_u8_stream_ctrl #(
      .PAD_VAL (8'hFF),
      .TIMEOUT (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_last       (m_last),
      .m_ready      (m_ready),
      .sort_vld_in  (sort_vld_in),
      .sort_din     (sort_din),
      .sort_vld_out (sort_vld_out),
      .sort_dout    (sort_dout),
      .err_timeout  (err_timeout),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (sort_vld_in === 1'b1) fire_cnt++;

   function automatic logic [255:0] sort_bytes(input logic [255:0] v);
      logic [7:0]   a [32];
      logic [7:0]   t;
      logic [255:0] r;
      for (int i = 0; i < 32; i++) a[i] = v[8*i +: 8];
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 31; j++) begin
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      for (int i = 0; i < 32; i++) r[8*i +: 8] = a[i];
      return r;
   endfunction

   // Sorter: sees vld_in in FIRE, answers in the following cycle.
   always begin
      @(negedge clk);
      if (sorter_on && sort_vld_in === 1'b1) begin
         mdl_dout = sort_bytes(sort_din);
         @(posedge clk); #1;
         mdl_vld = 1'b1;
         @(posedge clk); #1;
         mdl_vld = 1'b0;
      end
   end

   function automatic logic [255:0] mk_din(input int n);
      logic [255:0] r;
      for (int k = 0; k < 32; k++) r[8*k +: 8] = (k < n) ? frm[k] : 8'hFF;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_vld_in"}, sort_vld_in, 0);
      chk({tag, "_sort_din"}, sort_din, 0);
      chk({tag, "_err"}, err_timeout, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic send_frame(input int n, input bit use_last);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = frm[i];
         s_last  = use_last && (i == n - 1);
         @(negedge clk);
         chk("load_s_ready", s_ready, 1);
         chk("load_busy", busy, i != 0);
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Entered one cycle after the last input handshake; ends at the negedge of WAIT.
   task automatic fire_check(input bit short_f, input logic [255:0] exp_din);
      if (short_f) begin
         @(negedge clk);
         chk("pad_no_vld_in", sort_vld_in, 0);
         chk("pad_s_ready", s_ready, 0);
         chk("pad_busy", busy, 1);
         tick();
      end
      @(negedge clk);
      chk("fire_vld_in", sort_vld_in, 1);
      chk("fire_din", sort_din, exp_din);
      exp_fires++;
      tick();
      @(negedge clk);
      chk("wait_vld_in", sort_vld_in, 0);
      chk("wait_din_held", sort_din, exp_din);
      chk("wait_m_valid", m_valid, 0);
      chk("fire_count", fire_cnt, exp_fires);
   endtask

   task automatic drain(input int bp, input int abort_at, input int stray_at,
                        output int cyc_o);
      int  k;
      int  c;
      logic rdy;
      k = 0;
      c = 0;
      while (k < abort_at && c < 200) begin
         rdy       = (bp == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
         m_ready   = rdy;
         stray_vld = (c == stray_at);
         @(negedge clk);
         chk("drain_m_valid", m_valid, 1);
         chk("drain_m_data", m_data, exp_q[k]);
         chk("drain_m_last", m_last, k == 31);
         chk("drain_s_ready", s_ready, 0);
         if (rdy) k++;
         c++;
         tick();
      end
      m_ready   = 1'b0;
      stray_vld = 1'b0;
      chk("drain_bytes", k, abort_at);
      cyc_o = c;
   endtask

   task automatic post_drain();
      @(negedge clk);
      chk("done_m_valid", m_valid, 0);
      chk("done_m_last", m_last, 0);
      chk("done_s_ready", s_ready, 1);
      chk("done_busy", busy, 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      m_ready = 1'b0; stray_vld = 1'b0; sorter_on = 1'b1;
      tick();
      @(negedge clk);
      chk_zero("rst");
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rel_s_ready", s_ready, 0);
      tick();
      @(negedge clk);
      chk("idle_s_ready", s_ready, 1);
      chk("idle_busy", busy, 0);

      // Stray vld_out while idle in LOAD
      tick();
      stray_vld = 1'b1;
      tick();
      stray_vld = 1'b0;
      @(negedge clk);
      chk("stray_load_m_valid", m_valid, 0);
      chk("stray_load_s_ready", s_ready, 1);
      chk("stray_load_busy", busy, 0);
      tick();

      // Full frame, no s_last, stray pulse mid-drain
      frm   = full_in;
      exp_q = full_sorted;
      send_frame(32, 1'b0);
      fire_check(1'b0, mk_din(32));
      tick();
      drain(0, 32, 5, cyc);
      chk("full_drain_cycles", cyc, 32);
      post_drain();

      // Short frame
      frm[0] = 8'd9; frm[1] = 8'd3; frm[2] = 8'd7; frm[3] = 8'd1; frm[4] = 8'd5;
      for (int k = 0; k < 32; k++) exp_q[k] = 8'hFF;
      exp_q[0] = 8'd1; exp_q[1] = 8'd3; exp_q[2] = 8'd5; exp_q[3] = 8'd7; exp_q[4] = 8'd9;
      send_frame(5, 1'b1);
      fire_check(1'b1, mk_din(5));
      tick();
      drain(0, 32, -1, cyc);
      post_drain();

      // Backpressure 1,0,0,1 on a descending frame
      for (int k = 0; k < 32; k++) begin
         frm[k]   = 8'(31 - k);
         exp_q[k] = 8'(k);
      end
      send_frame(32, 1'b0);
      fire_check(1'b0, mk_din(32));
      tick();
      drain(1, 32, -1, cyc);
      chk("bp_drain_cycles", cyc, 64);
      post_drain();

      // Timeout: sorter silent
      sorter_on = 1'b0;
      frm[0] = 8'd50; frm[1] = 8'd40;
      send_frame(2, 1'b1);
      fire_check(1'b1, mk_din(2));
      for (int i = 1; i <= TMO; i++) begin
         chk("tmo_err_early", err_timeout, 0);
         chk("tmo_s_ready", s_ready, 0);
         tick();
         @(negedge clk);
      end
      chk("tmo_err_set", err_timeout, 1);
      chk("tmo_s_ready_back", s_ready, 1);
      chk("tmo_busy", busy, 0);
      tick();
      stray_vld = 1'b1;
      tick();
      stray_vld = 1'b0;
      @(negedge clk);
      chk("late_vld_out_m_valid", m_valid, 0);
      chk("late_vld_out_s_ready", s_ready, 1);
      tick();

      // Frame after timeout sorts normally; error stays sticky
      sorter_on = 1'b1;
      frm[0] = 8'd200; frm[1] = 8'd100; frm[2] = 8'd150;
      for (int k = 0; k < 32; k++) exp_q[k] = 8'hFF;
      exp_q[0] = 8'd100; exp_q[1] = 8'd150; exp_q[2] = 8'd200;
      send_frame(3, 1'b1);
      fire_check(1'b1, mk_din(3));
      tick();
      drain(0, 32, -1, cyc);
      chk("err_sticky", err_timeout, 1);
      post_drain();

      // Reset at drain byte 10
      for (int k = 0; k < 32; k++) begin
         frm[k]   = 8'(31 - k);
         exp_q[k] = 8'(k);
      end
      send_frame(32, 1'b0);
      fire_check(1'b0, mk_din(32));
      tick();
      drain(0, 10, -1, cyc);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk_zero("mid_rst");
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_rel_s_ready", s_ready, 0);
      tick();
      @(negedge clk);
      chk("mid_rst_idle_s_ready", s_ready, 1);
      tick();

      // Fresh full frame with s_last on slot 31
      frm   = full_in;
      exp_q = full_sorted;
      send_frame(32, 1'b1);
      fire_check(1'b0, mk_din(32));
      tick();
      drain(0, 32, -1, cyc);
      post_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
